char_grid_sampler: RTL and testbench
====================================

# char_grid_sampler

Samples a binarized character inside a bounding box onto a 5-column × 8-row grid and emits the 40-bit character vector consumed by the province template matcher. It sits between the character segmentation stage, which provides the box coordinates, and the template matcher. It produces one char vector per video frame.

## Interface
- COORD_W, 12, pixel coordinate width for hcnt/vcnt/box
- COLS, 5, grid columns (fixed; COLS*ROWS must equal 40)
- ROWS, 8, grid rows (fixed)

- pixelclk  in  1  pixel clock, sole clock
- reset  in  1  asynchronous, active-high reset
- i_vsync  in  1  frame sync; rising edge starts a frame
- i_de  in  1  active-video qualifier for i_bin/i_hcnt/i_vcnt
- i_bin  in  1  binarized pixel, 1 = stroke
- i_hcnt  in  COORD_W  current pixel x
- i_vcnt  in  COORD_W  current pixel y
- box_left, box_right, box_top, box_bottom  in  COORD_W each  inclusive character box
- box_valid  in  1  box usable this frame
- char  out  40  sampled grid; bit 39 = row0/col0 (top-left), raster order, bit index = 39 - (row*5+col)
- char_valid  out  1  one-cycle pulse when char updates

## Operation
- States: IDLE, SETUP, SAMPLE, DONE.
- IDLE: wait for i_vsync rising edge (edge-detect with a registered i_vsync).
- On the edge, from any state: latch the box and box_valid, go to SETUP.
- SETUP:
  - w = right-left+1, h = bottom-top+1, both COORD_W+1 bits.
  - If !box_valid, right<left+COLS-1, or bottom<top+ROWS-1, return to IDLE and drop the frame; char is unchanged and no pulse is issued.
  - Otherwise compute step_x = floor(w/5) with the sequential divider (COORD_W+1 cycles) and step_y = h>>3.
  - Then init row=0, col=0, tx = left + (step_x>>1), ty = top + (step_y>>1), and go to SAMPLE.
- SAMPLE: when i_de && i_vcnt==ty && i_hcnt==tx:
  - shadow[39-(row*5+col)] <= i_bin.
  - If col<4: col++, tx += step_x.
  - Else: col=0, tx = left+(step_x>>1), row++, ty += step_y.
  - The sample at row 7/col 4 moves to DONE.
- DONE: char <= shadow, char_valid=1 for exactly one cycle, then IDLE.
- Abort: an i_vsync rising edge in SETUP/SAMPLE discards the shadow, issues no pulse and restarts SETUP with the new box.
- Arithmetic: tx/ty accumulate in COORD_W+1 bits and never wrap. A target beyond the frame is never matched, so the frame is dropped by the next vsync.
- Box inputs are ignored except on the vsync edge.

## Timing
- Reset values: char=0, char_valid=0, state IDLE, shadow=0.
- i_bin is sampled in the same cycle as the coordinate match; there is no input pipeline.
- SETUP latency = COORD_W+3 cycles after the vsync edge. Upstream guarantees at least 16 cycles between the vsync edge and the first active pixel at box_top. Matches occurring during SETUP are not captured.
- char and char_valid update one cycle after the final sample cycle. char holds until the next DONE.
- Vsync edge and final sample in the same cycle: the abort wins, with no pulse.
- Reset mid-frame: return to IDLE immediately; outputs go to their reset values.

## Structure
- Package char_pkg holds CHAR_W=40, COLS, ROWS, COORD_W, the state enum and the bit-index function, shared with the template matcher so bit ordering is defined once.
- Sub-module char_div5: sequential restoring divide by 5 with start/done handshake. It is the only non-trivial arithmetic unit.

## Test plan
- Box 100..149 × 200..279 (step 10), all-ones stroke: samples at x=105..145, y=205..275 -> one char_valid, char=40'hFF_FFFF_FFFF.
- Same box, i_bin=1 only at (105,205) and (145,275) -> char=40'h80_0000_0001.
- Width 53 (left=100, right=152): step_x=10, samples still at x=105..145. A 1 only at x=150 is never sampled -> char=0.
- box_valid=0, or box_right=box_left+3 -> no char_valid; char keeps its previous value over 3 frames.
- Vsync re-asserted after row 4 -> no pulse. The next full frame produces a correct char and exactly one pulse.
- Assert reset during SAMPLE -> char=0 and char_valid=0 at once. The next frame samples normally.

Source files
------------

// File: rtl/char_pkg.sv
// Shared constants, FSM states and grid bit ordering for the character sampler
// and the template matcher, so the char-vector layout is defined in one place.
package char_pkg;
    localparam int CHAR_W  = 40;
    localparam int COLS    = 5;
    localparam int ROWS    = 8;
    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Raster order: row0/col0 lands in the MSB.
    function automatic logic [5:0] bit_index(input logic [2:0] row, input logic [2:0] col);
        return 6'(CHAR_W - 1 - (int'(row) * COLS + int'(col)));
    endfunction
endpackage

// File: rtl/char_div5.sv
// Sequential restoring divide-by-5: one quotient bit per cycle, W cycles after
// start, then a one-cycle done pulse with the quotient held until the next start.
module char_div5 #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     acc_reg;
    logic [2:0]       rem_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [3:0] trial;
    logic       ge;
    logic [2:0] rem_next;

    // Remainder stays below 5, so the shifted trial value fits in 4 bits.
    always_comb begin
        trial    = {rem_reg, acc_reg[W-1]};
        ge       = (trial >= 4'd5);
        rem_next = ge ? 3'(trial - 4'd5) : trial[2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            rem_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (start) begin
            acc_reg  <= dividend;
            rem_reg  <= '0;
            cnt_reg  <= CNT_W'(W);
            busy_reg <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (busy_reg) begin
                acc_reg <= {acc_reg[W-2:0], ge};
                rem_reg <= rem_next;
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done     = done_reg;
    assign quotient = acc_reg;
endmodule

// File: rtl/char_grid_sampler.sv
// Samples a binarized character box onto a 5x8 grid once per frame and emits
// the 40-bit raster-ordered char vector with a one-cycle valid pulse.
module char_grid_sampler #(
    parameter int COORD_W = 12,
    parameter int COLS    = 5,
    parameter int ROWS    = 8
) (
    input  logic               pixelclk,
    input  logic               reset,
    input  logic               i_vsync,
    input  logic               i_de,
    input  logic               i_bin,
    input  logic [COORD_W-1:0] i_hcnt,
    input  logic [COORD_W-1:0] i_vcnt,
    input  logic [COORD_W-1:0] box_left,
    input  logic [COORD_W-1:0] box_right,
    input  logic [COORD_W-1:0] box_top,
    input  logic [COORD_W-1:0] box_bottom,
    input  logic               box_valid,
    output logic [39:0]        char,
    output logic               char_valid
);
    import char_pkg::*;

    localparam int W1 = COORD_W + 1;

    state_t state_reg, state_next;

    logic               vsync_d_reg;
    logic [COORD_W-1:0] left_reg, right_reg, top_reg, bottom_reg;
    logic               bvalid_reg;
    logic [W1-1:0]      step_x_reg, step_y_reg, tx_reg, ty_reg;
    logic [2:0]         row_reg, col_reg;
    logic [39:0]        shadow_reg, shadow_next, char_reg;

    logic          vs_edge, box_ok, match, last;
    logic [W1-1:0] w_in, h_lat, step_y_new, div_q;
    logic          div_done;

    assign vs_edge    = i_vsync & ~vsync_d_reg;
    // The divider starts on the vsync edge straight from the box inputs, so
    // it runs in parallel with the validity check on the latched box.
    assign w_in       = {1'b0, box_right} - {1'b0, box_left} + W1'(1);
    assign h_lat      = {1'b0, bottom_reg} - {1'b0, top_reg} + W1'(1);
    assign step_y_new = h_lat >> 3;
    assign box_ok     = bvalid_reg
                        && ({1'b0, right_reg} >= {1'b0, left_reg} + W1'(COLS - 1))
                        && ({1'b0, bottom_reg} >= {1'b0, top_reg} + W1'(ROWS - 1));
    assign match      = i_de && ({1'b0, i_vcnt} == ty_reg) && ({1'b0, i_hcnt} == tx_reg);
    assign last       = (row_reg == 3'(ROWS - 1)) && (col_reg == 3'(COLS - 1));

    char_div5 #(.W(W1)) u_div5 (
        .clk      (pixelclk),
        .rst      (reset),
        .start    (vs_edge),
        .dividend (w_in),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (vs_edge) begin
            state_next = ST_SETUP;
        end else begin
            case (state_reg)
                ST_SETUP: begin
                    if (!box_ok)       state_next = ST_IDLE;
                    else if (div_done) state_next = ST_SAMPLE;
                end
                ST_SAMPLE: if (match && last) state_next = ST_DONE;
                ST_DONE:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        char_valid = 1'b0;
        if (state_reg == ST_DONE) char_valid = 1'b1;
    end

    always_comb begin
        shadow_next = shadow_reg;
        shadow_next[bit_index(row_reg, col_reg)] = i_bin;
    end

    // char is loaded on the final-sample edge so it is visible together with
    // the DONE pulse; an abort edge in that same cycle suppresses the load.
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            vsync_d_reg <= 1'b0;
            left_reg    <= '0;
            right_reg   <= '0;
            top_reg     <= '0;
            bottom_reg  <= '0;
            bvalid_reg  <= 1'b0;
            step_x_reg  <= '0;
            step_y_reg  <= '0;
            tx_reg      <= '0;
            ty_reg      <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            shadow_reg  <= '0;
            char_reg    <= '0;
        end else begin
            vsync_d_reg <= i_vsync;
            if (vs_edge) begin
                left_reg   <= box_left;
                right_reg  <= box_right;
                top_reg    <= box_top;
                bottom_reg <= box_bottom;
                bvalid_reg <= box_valid;
            end else if (state_reg == ST_SETUP) begin
                if (box_ok && div_done) begin
                    step_x_reg <= div_q;
                    step_y_reg <= step_y_new;
                    tx_reg     <= {1'b0, left_reg} + (div_q >> 1);
                    ty_reg     <= {1'b0, top_reg} + (step_y_new >> 1);
                    row_reg    <= '0;
                    col_reg    <= '0;
                    shadow_reg <= '0;
                end
            end else if (state_reg == ST_SAMPLE && match) begin
                shadow_reg <= shadow_next;
                if (col_reg == 3'(COLS - 1)) begin
                    col_reg <= '0;
                    tx_reg  <= {1'b0, left_reg} + (step_x_reg >> 1);
                    row_reg <= row_reg + 3'd1;
                    ty_reg  <= ty_reg + step_y_reg;
                end else begin
                    col_reg <= col_reg + 3'd1;
                    tx_reg  <= tx_reg + step_x_reg;
                end
                if (last) char_reg <= shadow_next;
            end
        end
    end

    assign char = char_reg;
endmodule

// File: tb/tb_char_grid_sampler.sv
// Frame-level bench: drives raster windows around each box and compares the
// char vector and pulse count against a grid-sampling reference model.
module tb_char_grid_sampler;
    logic        pixelclk = 1'b0;
    logic        reset;
    logic        i_vsync, i_de, i_bin;
    logic [11:0] i_hcnt, i_vcnt;
    logic [11:0] box_left, box_right, box_top, box_bottom;
    logic        box_valid;
    logic [39:0] char_o;
    logic        char_valid;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          seed = 0;
    logic [39:0] exp_char = '0;

    char_grid_sampler dut (
        .pixelclk   (pixelclk),
        .reset      (reset),
        .i_vsync    (i_vsync),
        .i_de       (i_de),
        .i_bin      (i_bin),
        .i_hcnt     (i_hcnt),
        .i_vcnt     (i_vcnt),
        .box_left   (box_left),
        .box_right  (box_right),
        .box_top    (box_top),
        .box_bottom (box_bottom),
        .box_valid  (box_valid),
        .char       (char_o),
        .char_valid (char_valid)
    );

    always #5 pixelclk = ~pixelclk;

    always @(negedge pixelclk) if (char_valid === 1'b1) pulses++;

    task automatic step(input int n);
        repeat (n) @(posedge pixelclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit pix(input int mode, input int x, input int y);
        int v;
        case (mode)
            0:       return 1'b1;
            1:       return ((x == 105) && (y == 205)) || ((x == 145) && (y == 275));
            2:       return x == 150;
            default: begin
                v = x * 7919 + y * 104729 + seed;
                return v[7] ^ v[12];
            end
        endcase
    endfunction

    // Grid centres: column c at left + sx/2 + c*sx, row r at top + sy/2 + r*sy.
    function automatic logic [39:0] model(input int l, input int r, input int t, input int b,
                                          input int mode);
        logic [39:0] m;
        int sx, sy;
        m  = '0;
        sx = (r - l + 1) / 5;
        sy = (b - t + 1) / 8;
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 5; cc++)
                m[39 - (rr * 5 + cc)] = pix(mode, l + sx / 2 + cc * sx, t + sy / 2 + rr * sy);
        return m;
    endfunction

    task automatic frame(input string tag, input int l, input int r, input int t, input int b,
                         input bit bv, input int mode, input int stop_y, input bit do_reset);
        int p0;
        bit full_ok;
        p0         = pulses;
        box_left   = 12'(l);
        box_right  = 12'(r);
        box_top    = 12'(t);
        box_bottom = 12'(b);
        box_valid  = bv;
        i_vsync    = 1'b1;
        step(2);
        i_vsync    = 1'b0;
        box_left   = 12'($urandom);
        box_right  = 12'($urandom);
        box_top    = 12'($urandom);
        box_bottom = 12'($urandom);
        box_valid  = 1'($urandom);
        step(20);
        for (int y = t - 1; y <= b + 1; y++) begin
            if (stop_y >= 0 && y == stop_y) break;
            for (int x = l - 2; x <= r + 2; x++) begin
                i_de   = 1'b1;
                i_hcnt = 12'(x);
                i_vcnt = 12'(y);
                i_bin  = pix(mode, x, y);
                step(1);
            end
            i_de = 1'b0;
            step(1);
        end
        i_de  = 1'b0;
        i_bin = 1'b0;
        if (do_reset) begin
            reset = 1'b1;
            #1;
            check({tag, " reset char"}, char_o, 40'h0);
            check({tag, " reset valid"}, {39'h0, char_valid}, 40'h0);
            exp_char = '0;
            step(1);
            reset = 1'b0;
            step(1);
        end else begin
            step(3);
            full_ok = (stop_y < 0) && bv && (r >= l + 4) && (b >= t + 7);
            if (full_ok) exp_char = model(l, r, t, b, mode);
            check({tag, " pulses"}, 40'(pulses - p0), full_ok ? 40'd1 : 40'd0);
            check({tag, " char"}, char_o, exp_char);
        end
    endtask

    initial begin
        int l, wd, t, hg;
        bit bv;
        reset      = 1'b1;
        i_vsync    = 1'b0;
        i_de       = 1'b0;
        i_bin      = 1'b0;
        i_hcnt     = '0;
        i_vcnt     = '0;
        box_left   = '0;
        box_right  = '0;
        box_top    = '0;
        box_bottom = '0;
        box_valid  = 1'b0;
        step(3);
        check("init char", char_o, 40'h0);
        check("init valid", {39'h0, char_valid}, 40'h0);
        reset = 1'b0;
        step(2);

        frame("all_ones", 100, 149, 200, 279, 1'b1, 0, -1, 1'b0);
        check("all_ones literal", char_o, 40'hFF_FFFF_FFFF);
        frame("width53", 100, 152, 200, 279, 1'b1, 2, -1, 1'b0);
        frame("corners", 100, 149, 200, 279, 1'b1, 1, -1, 1'b0);
        check("corners literal", char_o, 40'h80_0000_0001);

        frame("inval_bv0a", 100, 149, 200, 279, 1'b0, 0, -1, 1'b0);
        frame("inval_bv0b", 100, 149, 200, 279, 1'b0, 0, -1, 1'b0);
        frame("inval_narrow", 100, 103, 200, 279, 1'b1, 0, -1, 1'b0);

        frame("abort_part", 100, 149, 200, 279, 1'b1, 0, 246, 1'b0);
        seed = 12345;
        frame("after_abort", 100, 149, 200, 279, 1'b1, 3, -1, 1'b0);

        frame("reset_mid", 100, 149, 200, 279, 1'b1, 0, 250, 1'b1);
        seed = 777;
        frame("after_reset", 100, 149, 200, 279, 1'b1, 3, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            l    = int'($urandom_range(200, 2));
            wd   = int'($urandom_range(40, 3));
            t    = int'($urandom_range(200, 1));
            hg   = int'($urandom_range(48, 6));
            bv   = ($urandom_range(4, 0) != 0);
            seed = int'($urandom);
            frame($sformatf("rnd%0d", i), l, l + wd - 1, t, t + hg - 1, bv, 3, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
